// File: rtl/adat_rx_ctrl.sv
// Lock/sequencing controller for one ADAT receiver channel: qualifies frames by
// period and sync, runs lock/holdover, and forces deserializer re-sync on loss.
//
// state     | meaning
// ----------+------------------------------------------------------------
// UNLOCKED  | waiting for a frame with correct sync to start acquisition
// ACQUIRE   | counting consecutive good frames towards lock
// LOCKED    | forwarding each good frame's audio
// HOLDOVER  | repeating the last good sample across a short dropout
// RESYNC    | holding rx_rst for RESYNC_CYCLES, audio muted
module adat_rx_ctrl #(
   parameter int NOMINAL_PERIOD = 2048,
   parameter int PERIOD_TOL     = 8,
   parameter int LOCK_FRAMES    = 16,
   parameter int UNLOCK_FRAMES  = 4,
   parameter int TIMEOUT        = 4096,
   parameter int RESYNC_CYCLES  = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         frame_ready,
   input  logic         frame_valid,
   input  logic         smux_in,
   input  logic [191:0] audio_in,
   output logic         rx_rst,
   output logic         locked,
   output logic         sample_strobe,
   output logic [191:0] audio_out,
   output logic         smux_out,
   input  logic         err_clr,
   output logic [15:0]  err_cnt
);

   // audio buses carry 8 signed 24-bit lanes, lane i at [24*i +: 24]
   localparam int PW = $clog2(TIMEOUT + 1);
   localparam int GW = $clog2(LOCK_FRAMES + 1);
   localparam int BW = $clog2(UNLOCK_FRAMES + 1);
   localparam int RW = (RESYNC_CYCLES > 1) ? $clog2(RESYNC_CYCLES) : 1;

   localparam logic [PW-1:0] P_MIN  = PW'(NOMINAL_PERIOD - PERIOD_TOL);
   localparam logic [PW-1:0] P_MAX  = PW'(NOMINAL_PERIOD + PERIOD_TOL);
   localparam logic [PW-1:0] T_MAX  = PW'(TIMEOUT);
   localparam logic [GW-1:0] G_LAST = GW'(LOCK_FRAMES - 1);
   localparam logic [BW-1:0] B_LAST = BW'(UNLOCK_FRAMES - 1);
   localparam logic [RW-1:0] R_LAST = RW'(RESYNC_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_UNLOCKED,
      ST_ACQUIRE,
      ST_LOCKED,
      ST_HOLDOVER,
      ST_RESYNC
   } state_t;

   state_t        state, state_d;
   logic [PW-1:0] period_cnt;
   logic [GW-1:0] good_cnt, good_cnt_d;
   logic [BW-1:0] bad_cnt, bad_cnt_d;
   logic [RW-1:0] rs_cnt, rs_cnt_d;
   logic          first_flag, first_flag_d;
   logic          strobe_d, load_audio, clr_audio, err_inc;
   logic          period_ok, good, bad, timeout;

   assign period_ok = (period_cnt >= P_MIN) && (period_cnt <= P_MAX);
   assign good      = frame_ready && frame_valid && !first_flag && period_ok;
   assign bad       = frame_ready && !good;
   // a frame arriving in the timeout cycle is evaluated instead of timing out
   assign timeout   = (period_cnt == T_MAX) && !frame_ready;

   assign locked = (state == ST_LOCKED) || (state == ST_HOLDOVER);
   assign rx_rst = (state == ST_RESYNC);

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_UNLOCKED;
         period_cnt    <= '0;
         first_flag    <= 1'b1;
         good_cnt      <= '0;
         bad_cnt       <= '0;
         rs_cnt        <= '0;
         sample_strobe <= 1'b0;
         audio_out     <= '0;
         smux_out      <= 1'b0;
         err_cnt       <= '0;
      end else begin
         state         <= state_d;
         good_cnt      <= good_cnt_d;
         bad_cnt       <= bad_cnt_d;
         rs_cnt        <= rs_cnt_d;
         first_flag    <= first_flag_d;
         sample_strobe <= strobe_d;
         if (frame_ready)
            period_cnt <= PW'(1);
         else if (period_cnt != T_MAX)
            period_cnt <= period_cnt + PW'(1);
         if (clr_audio) begin
            audio_out <= '0;
            smux_out  <= 1'b0;
         end else if (load_audio) begin
            audio_out <= audio_in;
            smux_out  <= smux_in;
         end
         if (err_clr)
            err_cnt <= '0;
         else if (err_inc && (err_cnt != 16'hFFFF))
            err_cnt <= err_cnt + 16'd1;
      end
   end

   always_comb begin
      state_d      = state;
      good_cnt_d   = good_cnt;
      bad_cnt_d    = bad_cnt;
      rs_cnt_d     = rs_cnt;
      first_flag_d = first_flag && !frame_ready;
      strobe_d     = 1'b0;
      load_audio   = 1'b0;
      clr_audio    = 1'b0;
      err_inc      = 1'b0;
      case (state)
         ST_UNLOCKED: begin
            if (frame_ready && frame_valid) begin
               state_d    = ST_ACQUIRE;
               good_cnt_d = '0;
            end
         end
         ST_ACQUIRE: begin
            if (good) begin
               if (good_cnt == G_LAST) begin
                  state_d    = ST_LOCKED;
                  bad_cnt_d  = '0;
                  load_audio = 1'b1;
                  strobe_d   = 1'b1;
               end else begin
                  good_cnt_d = good_cnt + GW'(1);
               end
            end else if (bad) begin
               good_cnt_d = '0;
            end else if (timeout) begin
               state_d   = ST_RESYNC;
               rs_cnt_d  = '0;
               clr_audio = 1'b1;
            end
         end
         ST_LOCKED: begin
            if (good) begin
               load_audio = 1'b1;
               strobe_d   = 1'b1;
            end else if (bad) begin
               state_d   = ST_HOLDOVER;
               bad_cnt_d = BW'(1);
               strobe_d  = 1'b1;
               err_inc   = 1'b1;
            end else if (timeout) begin
               state_d   = ST_RESYNC;
               rs_cnt_d  = '0;
               clr_audio = 1'b1;
            end
         end
         ST_HOLDOVER: begin
            if (good) begin
               state_d    = ST_LOCKED;
               bad_cnt_d  = '0;
               load_audio = 1'b1;
               strobe_d   = 1'b1;
            end else if (bad) begin
               err_inc = 1'b1;
               if (bad_cnt == B_LAST) begin
                  state_d   = ST_RESYNC;
                  rs_cnt_d  = '0;
                  bad_cnt_d = '0;
                  clr_audio = 1'b1;
               end else begin
                  bad_cnt_d = bad_cnt + BW'(1);
                  strobe_d  = 1'b1;
               end
            end else if (timeout) begin
               state_d   = ST_RESYNC;
               rs_cnt_d  = '0;
               bad_cnt_d = '0;
               clr_audio = 1'b1;
            end
         end
         ST_RESYNC: begin
            clr_audio = 1'b1;
            if (rs_cnt == R_LAST) begin
               state_d      = ST_UNLOCKED;
               first_flag_d = 1'b1;
               good_cnt_d   = '0;
               bad_cnt_d    = '0;
            end else begin
               rs_cnt_d = rs_cnt + RW'(1);
            end
         end
         default: state_d = ST_UNLOCKED;
      endcase
   end

endmodule

// File: tb/tb_adat_rx_ctrl.sv
// Bench for adat_rx_ctrl: a short-period instance for the lock/holdover/loss
// sequences and a 1-cycle-frame instance that drives err_cnt into saturation.
module tb_adat_rx_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, frame_ready, frame_valid, smux_in, err_clr;
   logic [191:0] audio_in;
   logic         rx_rst, locked, sample_strobe, smux_out;
   logic [191:0] audio_out;
   logic [15:0]  err_cnt;

   logic         rst_s, fr_s, fv_s, clr_s;
   logic [191:0] aud_s;
   logic         rx_rst_s, locked_s, strobe_s, smux_out_s;
   logic [191:0] audio_out_s;
   logic [15:0]  err_s;
   logic         sat_done = 1'b0;

   adat_rx_ctrl #(
      .NOMINAL_PERIOD(32), .PERIOD_TOL(2), .LOCK_FRAMES(16),
      .UNLOCK_FRAMES(4), .TIMEOUT(64), .RESYNC_CYCLES(4)
   ) dut (
      .clk(clk), .rst(rst), .frame_ready(frame_ready), .frame_valid(frame_valid),
      .smux_in(smux_in), .audio_in(audio_in), .rx_rst(rx_rst), .locked(locked),
      .sample_strobe(sample_strobe), .audio_out(audio_out), .smux_out(smux_out),
      .err_clr(err_clr), .err_cnt(err_cnt)
   );

   adat_rx_ctrl #(
      .NOMINAL_PERIOD(1), .PERIOD_TOL(0), .LOCK_FRAMES(2),
      .UNLOCK_FRAMES(1024), .TIMEOUT(8), .RESYNC_CYCLES(4)
   ) dut_sat (
      .clk(clk), .rst(rst_s), .frame_ready(fr_s), .frame_valid(fv_s),
      .smux_in(1'b0), .audio_in(aud_s), .rx_rst(rx_rst_s), .locked(locked_s),
      .sample_strobe(strobe_s), .audio_out(audio_out_s), .smux_out(smux_out_s),
      .err_clr(clr_s), .err_cnt(err_s)
   );

   int checks   = 0;
   int failures = 0;
   int n;

   typedef struct packed {
      logic [191:0] audio;
      logic         smux;
   } exp_t;
   exp_t exp_q[$];
   exp_t e;

   task automatic chk_bit(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%0b required=%0b", name, act, req);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic chk_bus(input string name, input logic [191:0] act, input logic [191:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [191:0] pat(input int k);
      logic [191:0] r;
      for (int i = 0; i < 8; i++)
         r[24*i +: 24] = 24'(k * 4099 + i * 263) ^ 24'h800000;
      return r;
   endfunction

   task automatic expect_strobe(input logic [191:0] a, input logic s);
      exp_t x;
      x.audio = a;
      x.smux  = s;
      exp_q.push_back(x);
   endtask

   // frame_ready is sampled 'gap' edges after the previous frame; returns #1 after that edge
   task automatic frame(input int gap, input logic v, input logic s,
                        input logic [191:0] a, input logic clr);
      repeat (gap - 1) begin
         @(posedge clk);
         #1;
      end
      frame_ready = 1'b1;
      frame_valid = v;
      smux_in     = s;
      audio_in    = a;
      err_clr     = clr;
      @(posedge clk);
      #1;
      frame_ready = 1'b0;
      frame_valid = 1'b0;
      err_clr     = 1'b0;
   endtask

   // scoreboard monitor
   initial begin
      forever begin
         @(negedge clk);
         if (sample_strobe) begin
            if (exp_q.size() == 0) begin
               chk_bit("unexpected_strobe", sample_strobe, 1'b0);
            end else begin
               e = exp_q.pop_front();
               chk_bus("strobe_audio", audio_out, e.audio);
               chk_bit("strobe_smux", smux_out, e.smux);
            end
         end
      end
   end

   // saturation instance: one frame per cycle, 511 bad frames then 1 good per round
   initial begin
      rst_s = 1'b1; fr_s = 1'b0; fv_s = 1'b0; clr_s = 1'b0; aud_s = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_s = 1'b0;
      fr_s  = 1'b1;
      fv_s  = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk_bit("sat_locked", locked_s, 1'b1);
      for (int r = 0; r < 129; r++) begin
         fv_s = 1'b0;
         repeat (511) begin
            @(posedge clk);
            #1;
         end
         fv_s = 1'b1;
         @(posedge clk);
         #1;
         if (r == 0) chk_int("sat_err_round1", int'(err_s), 511);
      end
      chk_int("sat_err_saturated", int'(err_s), 65535);
      chk_bit("sat_still_locked", locked_s, 1'b1);
      fv_s  = 1'b0;
      clr_s = 1'b1;
      @(posedge clk);
      #1;
      clr_s = 1'b0;
      chk_int("sat_clr_wins", int'(err_s), 0);
      @(posedge clk);
      #1;
      chk_int("sat_err_after_clr", int'(err_s), 1);
      fr_s     = 1'b0;
      sat_done = 1'b1;
   end

   initial begin
      rst = 1'b1; frame_ready = 1'b0; frame_valid = 1'b0; smux_in = 1'b0;
      audio_in = '0; err_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_bit("rst_locked", locked, 1'b0);
      chk_bit("rst_rx_rst", rx_rst, 1'b0);
      chk_bit("rst_strobe", sample_strobe, 1'b0);
      chk_bus("rst_audio", audio_out, '0);
      chk_bit("rst_smux", smux_out, 1'b0);
      chk_int("rst_err", int'(err_cnt), 0);
      rst = 1'b0;

      // acquisition with tolerance edges, then an out-of-tolerance period
      frame(5, 1'b1, 1'b0, pat(0), 1'b0);
      frame(34, 1'b1, 1'b0, pat(1), 1'b0);
      frame(30, 1'b1, 1'b0, pat(2), 1'b0);
      for (int i = 0; i < 7; i++) frame(32, 1'b1, 1'b0, pat(3 + i), 1'b0);
      frame(35, 1'b1, 1'b0, pat(10), 1'b0);
      chk_bit("acq_after_bad_period", locked, 1'b0);
      for (int i = 0; i < 15; i++) frame(32, 1'b1, 1'b0, pat(11 + i), 1'b0);
      chk_bit("acq_15_good", locked, 1'b0);
      expect_strobe(pat(17), 1'b1);
      frame(32, 1'b1, 1'b1, pat(17), 1'b0);
      chk_bit("lock_16_good", locked, 1'b1);

      // holdover across two invalid frames
      expect_strobe(pat(18), 1'b0);
      frame(32, 1'b1, 1'b0, pat(18), 1'b0);
      expect_strobe(pat(18), 1'b0);
      frame(32, 1'b0, 1'b1, pat(19), 1'b0);
      chk_int("hold_err1", int'(err_cnt), 1);
      expect_strobe(pat(18), 1'b0);
      frame(32, 1'b0, 1'b1, pat(20), 1'b0);
      chk_int("hold_err2", int'(err_cnt), 2);
      chk_bit("hold_locked", locked, 1'b1);
      expect_strobe(pat(21), 1'b1);
      frame(32, 1'b1, 1'b1, pat(21), 1'b0);
      chk_bit("hold_recovered", locked, 1'b1);
      chk_int("hold_err_kept", int'(err_cnt), 2);

      // err_clr together with a bad frame
      expect_strobe(pat(21), 1'b1);
      frame(32, 1'b0, 1'b0, pat(22), 1'b1);
      chk_int("clr_with_bad", int'(err_cnt), 0);
      expect_strobe(pat(23), 1'b0);
      frame(32, 1'b1, 1'b0, pat(23), 1'b0);

      // sustained loss
      for (int i = 0; i < 3; i++) begin
         expect_strobe(pat(23), 1'b0);
         frame(32, 1'b0, 1'b1, pat(24 + i), 1'b0);
      end
      frame(32, 1'b0, 1'b1, pat(27), 1'b0);
      chk_int("loss_err4", int'(err_cnt), 4);
      chk_bit("loss_unlocked", locked, 1'b0);
      chk_bus("loss_audio_muted", audio_out, '0);
      chk_bit("loss_smux_muted", smux_out, 1'b0);
      n = 0;
      while (rx_rst && n < 10) begin
         n++;
         @(posedge clk);
         #1;
      end
      chk_int("loss_rx_rst_len", n, 4);

      // relock from UNLOCKED, then frame timeout
      frame(5, 1'b1, 1'b0, pat(30), 1'b0);
      for (int i = 0; i < 15; i++) frame(32, 1'b1, 1'b0, pat(31 + i), 1'b0);
      expect_strobe(pat(50), 1'b1);
      frame(32, 1'b1, 1'b1, pat(50), 1'b0);
      chk_bit("relock", locked, 1'b1);
      repeat (63) @(posedge clk);
      #1;
      chk_bit("timeout_not_yet", locked, 1'b1);
      @(posedge clk);
      #1;
      chk_bit("timeout_unlocked", locked, 1'b0);
      chk_bit("timeout_rx_rst", rx_rst, 1'b1);
      repeat (6) @(posedge clk);
      #1;

      // reset during ACQUIRE
      frame(5, 1'b1, 1'b0, pat(60), 1'b0);
      frame(32, 1'b1, 1'b0, pat(61), 1'b0);
      frame(32, 1'b1, 1'b0, pat(62), 1'b0);
      chk_int("pre_rst_err", int'(err_cnt), 4);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk_int("acq_rst_err", int'(err_cnt), 0);
      chk_bit("acq_rst_locked", locked, 1'b0);
      chk_bit("acq_rst_rx_rst", rx_rst, 1'b0);
      chk_bus("acq_rst_audio", audio_out, '0);
      frame(5, 1'b1, 1'b0, pat(63), 1'b0);
      for (int i = 0; i < 15; i++) frame(32, 1'b1, 1'b0, pat(64 + i), 1'b0);
      chk_bit("post_rst_15_good", locked, 1'b0);
      expect_strobe(pat(80), 1'b0);
      frame(32, 1'b1, 1'b0, pat(80), 1'b0);
      chk_bit("post_rst_lock", locked, 1'b1);

      // reset during RESYNC
      for (int i = 0; i < 3; i++) begin
         expect_strobe(pat(80), 1'b0);
         frame(32, 1'b0, 1'b0, pat(81 + i), 1'b0);
      end
      frame(32, 1'b0, 1'b0, pat(84), 1'b0);
      chk_bit("resync_entered", rx_rst, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk_bit("resync_rst_rx_rst", rx_rst, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk_bit("resync_rst_stays_low", rx_rst, 1'b0);

      for (int i = 0; i < 80000 && !sat_done; i++) @(posedge clk);
      chk_bit("sat_done", sat_done, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      chk_int("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/adat_rx_ctrl.md
Name: adat_rx_ctrl

Overview:
Lock/sequencing controller for one ADAT receiver channel. It sits directly behind the ADAT deserializer and consumes its per-frame strobe, valid flag, user bits and 8x24-bit audio bus. It measures the frame period and qualifies frames to run a lock state machine. It forwards audio only while locked, repeats the last good sample across short dropouts, and pulses the deserializer's reset to force re-sync on sustained loss.

Parameters:
NOMINAL_PERIOD, 2048, expected clk cycles per frame (48 kHz at 98.304 MHz)
PERIOD_TOL, 8, allowed +/- deviation of the measured period, in cycles
LOCK_FRAMES, 16, consecutive good frames required to declare lock
UNLOCK_FRAMES, 4, consecutive bad frames in HOLDOVER that force RESYNC
TIMEOUT, 4096, cycles without frame_ready that force RESYNC; must be > NOMINAL_PERIOD+PERIOD_TOL
RESYNC_CYCLES, 4, length of the rx_rst pulse

Ports:
clk  in  1  system clock, 98.304 MHz
rst  in  1  synchronous, active-high reset
frame_ready  in  1  one-cycle strobe from the deserializer: new frame parsed
frame_valid  in  1  frame sync bits correct; sampled only when frame_ready=1
smux_in  in  1  S/MUX user bit of the frame
audio_in  in  8x24 signed  channel samples, stable while frame_ready=1
rx_rst  out  1  synchronous reset to the deserializer
locked  out  1  high in LOCKED or HOLDOVER
sample_strobe  out  1  one-cycle pulse when audio_out is (re)issued
audio_out  out  8x24 signed  qualified audio
smux_out  out  1  S/MUX bit of the last good frame
err_clr  in  1  clears err_cnt
err_cnt  out  16  saturating count of bad frames seen while locked

Behaviour:
- Reset (rst=1): state UNLOCKED; all outputs 0; period_cnt=0; first_flag=1; good_cnt=0; bad_cnt=0. rst overrides every other input.
- period_cnt width = clog2(TIMEOUT+1). Each cycle: if frame_ready, period_cnt<=1; otherwise it increments, saturating at TIMEOUT. The measured period is the value of period_cnt in the frame_ready cycle.
- good frame: frame_ready & frame_valid & !first_flag & |period - NOMINAL_PERIOD| <= PERIOD_TOL. bad frame: frame_ready & !good.
- first_flag: set by reset and on entry to UNLOCKED; cleared on the first frame_ready. That first frame is neither good nor bad.
- timeout: period_cnt==TIMEOUT in any state except UNLOCKED and RESYNC.
- UNLOCKED: frame_ready & frame_valid -> ACQUIRE with good_cnt=0. Invalid frames are ignored.
- ACQUIRE: good frame increments good_cnt; reaching LOCK_FRAMES -> LOCKED, and that frame is forwarded. A bad frame sets good_cnt=0 and stays in ACQUIRE. timeout -> RESYNC.
- LOCKED:
  - good frame: register audio_in and smux_in into audio_out/smux_out; pulse sample_strobe.
  - bad frame: -> HOLDOVER with bad_cnt=1; pulse sample_strobe with audio_out unchanged (repeat last sample); err_cnt++.
  - timeout -> RESYNC.
- HOLDOVER:
  - good frame: -> LOCKED with bad_cnt=0; audio updated and strobed.
  - bad frame: bad_cnt++; err_cnt++; sample repeated and strobed; when bad_cnt reaches UNLOCK_FRAMES -> RESYNC with no strobe on that frame.
  - timeout -> RESYNC.
- RESYNC: rx_rst=1 for exactly RESYNC_CYCLES cycles; audio_out=0, smux_out=0, locked=0, frame_ready ignored; then -> UNLOCKED.
- Latency: audio_out, smux_out, sample_strobe and locked are registered and update 1 cycle after the frame_ready cycle.
- sample_strobe never lasts more than 1 cycle. It is never asserted in UNLOCKED, ACQUIRE or RESYNC.
- err_cnt saturates at 0xFFFF. When err_clr and an increment occur in the same cycle, clear wins (result 0).
- timeout and frame_ready in the same cycle: the frame is evaluated; timeout is ignored.
- rst asserted mid-RESYNC: rx_rst drops the next cycle and the controller returns to UNLOCKED.

Test Plan:
- Nominal lock: 17 valid frames at 2048-cycle spacing -> locked rises 1 cycle after the 17th frame_ready; sample_strobe on the 17th frame with audio_out = audio_in.
- Tolerance edge: periods of 2056 and 2040 -> counted good. A period of 2057 in ACQUIRE -> good_cnt resets, and lock needs 16 further good frames.
- Holdover: in LOCKED, 2 invalid frames then 1 good frame -> 2 strobes repeating the prior sample values, locked stays 1, err_cnt=2, then a new sample is issued.
- Loss: in LOCKED, 4 consecutive invalid frames -> no strobe on the 4th; rx_rst high for 4 cycles; audio_out=0; state ends in UNLOCKED.
- Timeout: in LOCKED, no frame_ready for 4096 cycles -> RESYNC entered; locked=0 on the next cycle.
- Counter edges: force 65536 bad frames -> err_cnt holds 0xFFFF. err_clr coincident with a bad frame -> err_cnt=0. rst mid-ACQUIRE -> all outputs 0 next cycle.
